// File: rtl/apb4_crc_mst.sv
// APB4 initiator that runs a multi-word CRC job on the CRC peripheral, chaining the raw CRC state
// through INIT between words. Optional macro CRC_MST_TIMEOUT_EN bounds STAT polling to POLL_MAX reads.
module apb4_crc_mst #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LEN_WIDTH = 16,
  parameter int unsigned POLL_MAX  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [1:0]           mode_i,
  input  logic [1:0]           size_i,
  input  logic                 revin_i,
  input  logic                 revout_i,
  input  logic [31:0]          init_i,
  input  logic [31:0]          xorv_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic [31:0]          word_i,
  input  logic                 word_valid_i,
  output logic                 word_ready_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [31:0]          result_o,
  output logic [31:0]          paddr_o,
  output logic                 psel_o,
  output logic                 penable_o,
  output logic                 pwrite_o,
  output logic [31:0]          pwdata_o,
  output logic [3:0]           pstrb_o,
  input  logic                 pready_i,
  input  logic [31:0]          prdata_i,
  input  logic                 pslverr_i
);

  localparam logic [31:0] OFF_CTRL = 32'h00;
  localparam logic [31:0] OFF_INIT = 32'h04;
  localparam logic [31:0] OFF_XORV = 32'h08;
  localparam logic [31:0] OFF_DATA = 32'h0C;
  localparam logic [31:0] OFF_STAT = 32'h10;

  typedef enum logic [3:0] {
    S_IDLE, S_CFG_XORV, S_CFG_CTRL, S_WR_INIT, S_WAIT_WORD, S_LAST_CTRL,
    S_LAST_XORV, S_WR_DATA, S_POLL, S_RD_RES, S_FIN
  } state_e;

  state_e               state_q, state_d;
  logic                 acc_q, acc_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [1:0]           mode_q, mode_d;
  logic [1:0]           size_q, size_d;
  logic                 revin_q, revin_d;
  logic                 revout_q, revout_d;
  logic [31:0]          xorv_q, xorv_d;
  logic [31:0]          chain_q, chain_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          word_q, word_d;
  logic                 last_q, last_d;
  logic [31:0]          result_q, result_d;
  logic                 apb_act, xfer_ok, abort;
`ifdef CRC_MST_TIMEOUT_EN
  localparam int unsigned PW = $clog2(POLL_MAX) + 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);
  logic [PW-1:0] poll_q, poll_d;
`endif

  always_comb begin
    state_d = state_q;   acc_d = acc_q;       busy_d = busy_q;
    done_d = 1'b0;       err_d = 1'b0;        mode_d = mode_q;
    size_d = size_q;     revin_d = revin_q;   revout_d = revout_q;
    xorv_d = xorv_q;     chain_d = chain_q;   cnt_d = cnt_q;
    word_d = word_q;     last_d = last_q;     result_d = result_q;
    psel_o = 1'b0;       penable_o = 1'b0;    pwrite_o = 1'b0;
    paddr_o = 32'd0;     pwdata_o = 32'd0;    word_ready_o = 1'b0;
    apb_act = 1'b0;      xfer_ok = 1'b0;      abort = 1'b0;
`ifdef CRC_MST_TIMEOUT_EN
    poll_d = poll_q;
`endif

    // Transfer attributes depend only on the state, so they hold across wait states.
    case (state_q)
      S_CFG_XORV:  begin apb_act = 1'b1; pwrite_o = 1'b1; paddr_o = BASE_ADDR + OFF_XORV; end
      S_CFG_CTRL:  begin apb_act = 1'b1; pwrite_o = 1'b1; paddr_o = BASE_ADDR + OFF_CTRL;
                         pwdata_o = {25'd0, size_q, mode_q, 1'b0, revin_q, 1'b1}; end
      S_WR_INIT:   begin apb_act = 1'b1; pwrite_o = 1'b1; paddr_o = BASE_ADDR + OFF_INIT;
                         pwdata_o = chain_q; end
      S_LAST_CTRL: begin apb_act = 1'b1; pwrite_o = 1'b1; paddr_o = BASE_ADDR + OFF_CTRL;
                         pwdata_o = {25'd0, size_q, mode_q, revout_q, revin_q, 1'b1}; end
      S_LAST_XORV: begin apb_act = 1'b1; pwrite_o = 1'b1; paddr_o = BASE_ADDR + OFF_XORV;
                         pwdata_o = xorv_q; end
      S_WR_DATA:   begin apb_act = 1'b1; pwrite_o = 1'b1; paddr_o = BASE_ADDR + OFF_DATA;
                         pwdata_o = word_q; end
      S_POLL:      begin apb_act = 1'b1; paddr_o = BASE_ADDR + OFF_STAT; end
      S_RD_RES:    begin apb_act = 1'b1; paddr_o = BASE_ADDR + OFF_DATA; end
      S_FIN:       begin apb_act = 1'b1; pwrite_o = 1'b1; paddr_o = BASE_ADDR + OFF_CTRL; end
      default: ;
    endcase

    if (apb_act) begin
      psel_o    = 1'b1;
      penable_o = acc_q;
      if (!acc_q) begin
        acc_d = 1'b1;
      end else if (pready_i) begin
        acc_d = 1'b0;
        if (pslverr_i) abort = 1'b1;
        else           xfer_ok = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (len_i == '0) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            mode_d = mode_i;   size_d = size_i;   revin_d = revin_i;  revout_d = revout_i;
            xorv_d = xorv_i;   chain_d = init_i;  cnt_d = len_i;      busy_d = 1'b1;
            acc_d  = 1'b0;     state_d = S_CFG_XORV;
          end
        end
      end
      S_CFG_XORV:  if (xfer_ok) state_d = S_CFG_CTRL;
      S_CFG_CTRL:  if (xfer_ok) state_d = S_WR_INIT;
      S_WR_INIT:   if (xfer_ok) state_d = S_WAIT_WORD;
      S_WAIT_WORD: begin
        word_ready_o = 1'b1;
        if (word_valid_i) begin
          word_d  = word_i;
          cnt_d   = cnt_q - LEN_WIDTH'(1);
          last_d  = (cnt_q == LEN_WIDTH'(1));
          state_d = (cnt_q == LEN_WIDTH'(1)) ? S_LAST_CTRL : S_WR_DATA;
        end
      end
      S_LAST_CTRL: if (xfer_ok) state_d = S_LAST_XORV;
      S_LAST_XORV: if (xfer_ok) state_d = S_WR_DATA;
      S_WR_DATA: begin
        if (xfer_ok) begin
          state_d = S_POLL;
`ifdef CRC_MST_TIMEOUT_EN
          poll_d = '0;
`endif
        end
      end
      S_POLL: begin
        if (xfer_ok && prdata_i[0]) begin
          state_d = S_RD_RES;
        end
`ifdef CRC_MST_TIMEOUT_EN
        else if (xfer_ok) begin
          if (poll_q == POLL_LAST) abort = 1'b1;
          else                     poll_d = poll_q + PW'(1);
        end
`endif
      end
      S_RD_RES: begin
        if (xfer_ok) begin
          // Intermediate words run with revout=0/xorv=0, so DATA is the raw state to chain.
          if (last_q) begin result_d = prdata_i; state_d = S_FIN;     end
          else        begin chain_d  = prdata_i; state_d = S_WR_INIT; end
        end
      end
      S_FIN: begin
        if (xfer_ok) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
      acc_d   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;  acc_q <= 1'b0;    busy_q <= 1'b0;   done_q <= 1'b0;
      err_q <= 1'b0;      mode_q <= 2'd0;   size_q <= 2'd0;   revin_q <= 1'b0;
      revout_q <= 1'b0;   xorv_q <= 32'd0;  chain_q <= 32'd0; cnt_q <= '0;
      word_q <= 32'd0;    last_q <= 1'b0;   result_q <= 32'd0;
`ifdef CRC_MST_TIMEOUT_EN
      poll_q <= '0;
`endif
    end else begin
      state_q <= state_d;  acc_q <= acc_d;    busy_q <= busy_d;   done_q <= done_d;
      err_q <= err_d;      mode_q <= mode_d;  size_q <= size_d;   revin_q <= revin_d;
      revout_q <= revout_d; xorv_q <= xorv_d; chain_q <= chain_d; cnt_q <= cnt_d;
      word_q <= word_d;    last_q <= last_d;  result_q <= result_d;
`ifdef CRC_MST_TIMEOUT_EN
      poll_q <= poll_d;
`endif
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign result_o = result_q;
  assign pstrb_o  = 4'hF;

endmodule

// File: tb/tb_apb4_crc_mst.sv
// Bench for apb4_crc_mst: behavioural CRC peripheral on APB plus a whole-message CRC reference;
// expected job outcomes are queued at issue time and checked by a monitor on done_o.
module tb_apb4_crc_mst;
  localparam logic [31:0] BASE = 32'h0000_4000;
  localparam int LW = 16;

  logic clk = 1'b0, rst_i = 1'b1;
  logic start_i = 0, revin_i = 0, revout_i = 0, word_valid_i = 0;
  logic [1:0] mode_i = 0, size_i = 0;
  logic [31:0] init_i = 0, xorv_i = 0, word_i = 0;
  logic [LW-1:0] len_i = 0;
  logic word_ready_o, busy_o, done_o, err_o, psel_o, penable_o, pwrite_o;
  logic [31:0] result_o, paddr_o, pwdata_o;
  logic [3:0] pstrb_o;
  logic pready_i = 0, pslverr_i = 0;
  logic [31:0] prdata_i = 0;

  apb4_crc_mst #(.BASE_ADDR(BASE), .LEN_WIDTH(LW), .POLL_MAX(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i), .size_i(size_i),
    .revin_i(revin_i), .revout_i(revout_i), .init_i(init_i), .xorv_i(xorv_i), .len_i(len_i),
    .word_i(word_i), .word_valid_i(word_valid_i), .word_ready_o(word_ready_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .result_o(result_o), .paddr_o(paddr_o), .psel_o(psel_o),
    .penable_o(penable_o), .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- CRC arithmetic (plain bitwise definition) ----------------
  function automatic int cw(input logic [1:0] m);
    return (m == 2'd0) ? 8 : (m == 2'd3) ? 32 : 16;
  endfunction
  function automatic logic [31:0] cpoly(input logic [1:0] m);
    case (m)
      2'd0: return 32'h07;
      2'd1: return 32'h1021;
      2'd2: return 32'h8005;
      default: return 32'h04C1_1DB7;
    endcase
  endfunction
  function automatic logic [31:0] cmask(input logic [1:0] m);
    return (m == 2'd3) ? 32'hFFFF_FFFF : ((32'd1 << cw(m)) - 32'd1);
  endfunction
  function automatic logic [31:0] refl(input logic [31:0] v, input int n);
    logic [31:0] r = 32'd0;
    for (int i = 0; i < n; i++) r[n-1-i] = v[i];
    return r;
  endfunction
  function automatic logic [31:0] crc_byte(input logic [31:0] st_in, input logic [7:0] b,
                                           input logic [1:0] m, input logic ri);
    logic [31:0] st, bb;
    int w = cw(m);
    bb = ri ? refl({24'd0, b}, 8) : {24'd0, b};
    st = (st_in & cmask(m)) ^ (bb << (w - 8));
    for (int k = 0; k < 8; k++) begin
      if (st[w-1]) st = (st << 1) ^ cpoly(m);
      else         st = st << 1;
      st = st & cmask(m);
    end
    return st;
  endfunction
  function automatic logic [31:0] crc_fin(input logic [31:0] st, input logic [1:0] m,
                                          input logic ro, input logic [31:0] x);
    logic [31:0] v = st & cmask(m);
    if (ro) v = refl(v, cw(m));
    return (v ^ x) & cmask(m);
  endfunction

  // Reference: CRC over the whole byte message in one pass, no chaining.
  logic [7:0] msg[$];
  function automatic logic [31:0] ref_crc(input logic [1:0] m, input logic ri, input logic ro,
                                          input logic [31:0] init, input logic [31:0] x);
    logic [31:0] st = init & cmask(m);
    foreach (msg[i]) st = crc_byte(st, msg[i], m, ri);
    return crc_fin(st, m, ro, x);
  endfunction

  // ---------------- Scoreboard ----------------
  typedef struct packed { logic [1:0] kind; logic err; logic [31:0] res; } exp_t; // kind 0 ok,1 abort,2 len0
  exp_t sb[$];
  logic [31:0] wexp[$];
  logic [31:0] exp_result = 32'd0, exp_init = 32'd0;
  int done_seen = 0, xfer_cnt = 0;
  logic [31:0] last_addr = 0, last_wdata = 0;
  logic last_write = 0, last_err = 0;

  // ---------------- CRC peripheral model ----------------
  logic [31:0] s_ctrl = 0, s_state = 0, s_xorv = 0, rnd;
  int s_pending = 0, hold_cnt = 0;
  bit s_done = 0, err_arm = 0, hold_arm = 0;
  bit pend = 0, p_write = 0;
  logic [31:0] p_addr = 0, p_wdata = 0;

  always @(negedge clk) begin
    if (rst_i) begin
      pend = 0; pready_i = 0; pslverr_i = 0; hold_cnt = 0;
    end else begin
      if (pend) begin
        check("apb_hold_ctl", 32'({psel_o, penable_o, pwrite_o}), 32'({2'b11, p_write}));
        check("apb_hold_addr", paddr_o, p_addr);
        check("apb_hold_wdata", pwdata_o, p_wdata);
      end
      pslverr_i = 0;
      rnd = $urandom;
      if (psel_o && penable_o) begin
        if (hold_arm && !pwrite_o && paddr_o == BASE + 32'h10) begin hold_cnt = 5; hold_arm = 0; end
        if (hold_cnt > 0) begin pready_i = 0; hold_cnt--; end
        else pready_i = ($urandom_range(0, 2) != 0);
        if (err_arm && pwrite_o && paddr_o == BASE + 32'h0C) begin pready_i = 1; pslverr_i = 1; err_arm = 0; end
        if (!pwrite_o && paddr_o == BASE + 32'h10)      prdata_i = {rnd[31:1], s_done && s_pending == 0};
        else if (!pwrite_o && paddr_o == BASE + 32'h0C) prdata_i = crc_fin(s_state, s_ctrl[4:3], s_ctrl[2], s_xorv);
        else prdata_i = rnd;
        if (pready_i) begin
          xfer_cnt++;
          last_addr = paddr_o; last_wdata = pwdata_o; last_write = pwrite_o; last_err = pslverr_i;
          if (pwrite_o && paddr_o == BASE + 32'h0C) begin
            if (wexp.size() == 0) check("data_word_extra", 32'd1, 32'd0);
            else check("data_word", pwdata_o, wexp.pop_front());
          end
          if (!pslverr_i) begin
            if (pwrite_o) begin
              case (paddr_o - BASE)
                32'h00: s_ctrl = pwdata_o;
                32'h04: begin check("init_chain", pwdata_o, exp_init); s_state = pwdata_o; end
                32'h08: s_xorv = pwdata_o;
                32'h0C: begin
                  for (int k = int'(s_ctrl[6:5]); k >= 0; k--)
                    s_state = crc_byte(s_state, pwdata_o[8*k +: 8], s_ctrl[4:3], s_ctrl[1]);
                  s_pending = $urandom_range(0, 3);
                  s_done = 1;
                end
                default: check("bad_write_addr", paddr_o, BASE);
              endcase
            end else if (paddr_o == BASE + 32'h10) begin
              if (s_done) begin
                if (s_pending == 0) s_done = 0;
                else s_pending--;
              end
            end else if (paddr_o == BASE + 32'h0C) begin
              exp_init = prdata_i;
            end
          end
        end
      end else begin
        pready_i = $urandom_range(0, 1);
        prdata_i = rnd;
      end
      pend = psel_o && !(penable_o && pready_i);
      p_addr = paddr_o; p_write = pwrite_o; p_wdata = pwdata_o;
    end
  end

  // ---------------- Monitor ----------------
  exp_t e;
  always @(negedge clk) begin
    if (!rst_i) begin
      check("pstrb", 32'(pstrb_o), 32'hF);
      check("psel_without_busy", 32'(psel_o & ~busy_o), 32'd0);
      check("ready_during_apb", 32'(word_ready_o & psel_o), 32'd0);
      if (done_o) begin
        if (sb.size() == 0) check("done_unexpected", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          check("done_err", 32'(err_o), 32'(e.err));
          check("result", result_o, e.res);
          if (e.kind == 2'd0) begin
            check("fin_addr", last_addr, BASE);
            check("fin_en0", 32'({last_write, last_wdata[0]}), 32'h2);
          end else if (e.kind == 2'd1) begin
            check("abort_was_last", 32'(last_err), 32'd1);
          end
        end
        done_seen++;
      end
    end
  end

  // ---------------- Stimulus ----------------
  logic [31:0] job_words[$];

  task automatic issue_start(input logic [1:0] m, input logic [1:0] sz, input logic ri,
                             input logic ro, input logic [31:0] init, input logic [31:0] xv,
                             input int n);
    @(negedge clk);
    exp_init = init;
    mode_i = m; size_i = sz; revin_i = ri; revout_i = ro; init_i = init; xorv_i = xv;
    len_i = LW'(n); start_i = 1;
    @(negedge clk);
    start_i = 0;
    mode_i = 2'($urandom); size_i = 2'($urandom); init_i = $urandom; xorv_i = $urandom;
    revin_i = 1'($urandom); revout_i = 1'($urandom); len_i = LW'($urandom);
  endtask

  task automatic feed_word(input logic [31:0] w, input int gap);
    int t = 0;
    repeat (gap) @(negedge clk);
    word_valid_i = 1; word_i = w;
    wexp.push_back(w);
    while (!word_ready_o && t < 3000) begin @(negedge clk); t++; end
    check("word_accept", 32'(t < 3000), 32'd1);
    @(negedge clk);
    word_valid_i = 0; word_i = $urandom;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_seen < target && t < 5000) begin @(negedge clk); t++; end
    check("done_seen", 32'(done_seen), 32'(target));
  endtask

  task automatic run_job(input logic [1:0] m, input logic [1:0] sz, input logic ri, input logic ro,
                         input logic [31:0] init, input logic [31:0] xv, input int gap_at,
                         input int gap_len, input bit restart_mid, input bit use_const,
                         input logic [31:0] cval);
    logic [31:0] r;
    int n = job_words.size();
    int target = done_seen + 1;
    msg.delete();
    foreach (job_words[i])
      for (int k = int'(sz); k >= 0; k--) msg.push_back(job_words[i][8*k +: 8]);
    r = use_const ? cval : ref_crc(m, ri, ro, init, xv);
    sb.push_back('{kind: 2'd0, err: 1'b0, res: r});
    exp_result = r;
    issue_start(m, sz, ri, ro, init, xv, n);
    for (int i = 0; i < n; i++) begin
      feed_word(job_words[i], (i == gap_at) ? gap_len : 0);
      if (restart_mid && i == 0) begin
        start_i = 1; len_i = LW'(2);
        @(negedge clk);
        start_i = 0;
      end
    end
    wait_done(target);
  endtask

  task automatic load_ascii();
    job_words.delete();
    for (int i = 0; i < 9; i++) job_words.push_back(32'h31 + 32'(i));
  endtask

  initial begin
    int snap, t;
    logic [1:0] m, sz;
    logic [31:0] wm;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({psel_o, penable_o, pwrite_o, busy_o, done_o, err_o, word_ready_o}), 32'd0);
    check("reset_paddr", paddr_o, 32'd0);
    check("reset_pwdata", pwdata_o, 32'd0);
    check("reset_result", result_o, 32'd0);
    check("reset_pstrb", 32'(pstrb_o), 32'hF);
    rst_i = 0;
    @(negedge clk);

    // Zero-length job: immediate error completion, no bus traffic.
    snap = xfer_cnt;
    sb.push_back('{kind: 2'd2, err: 1'b1, res: exp_result});
    issue_start(2'd3, 2'd0, 1'b0, 1'b0, 32'd0, 32'd0, 0);
    check("len0_done_err", 32'({done_o, err_o}), 32'h3);
    repeat (5) @(negedge clk);
    check("len0_no_xfer", 32'(xfer_cnt), 32'(snap));

    load_ascii();
    run_job(2'd3, 2'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 0, 0, 1, 32'hCBF4_3926);
    run_job(2'd0, 2'd0, 1'b0, 1'b0, 32'd0, 32'd0, -1, 0, 0, 1, 32'h0000_00F4);
    run_job(2'd1, 2'd0, 1'b0, 1'b0, 32'h0000_FFFF, 32'd0, -1, 0, 0, 1, 32'h0000_29B1);

    // Slave error on the first DATA write of a three-word job.
    err_arm = 1;
    exp_init = 32'h1234;
    sb.push_back('{kind: 2'd1, err: 1'b1, res: exp_result});
    snap = done_seen + 1;
    issue_start(2'd3, 2'd3, 1'b0, 1'b0, 32'h1234, 32'h0, 3);
    feed_word(32'hDEAD_BEEF, 0);
    wait_done(snap);
    snap = xfer_cnt;
    repeat (20) @(negedge clk);
    check("no_xfer_after_abort", 32'(xfer_cnt), 32'(snap));
    check("no_busy_after_abort", 32'(busy_o), 32'd0);

    // POLL wait states plus a long gap in the word stream.
    hold_arm = 1;
    load_ascii();
    run_job(2'd3, 2'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 10, 0, 1, 32'hCBF4_3926);

    for (int j = 0; j < 8; j++) begin
      m = 2'($urandom); sz = 2'($urandom);
      wm = (sz == 2'd3) ? 32'hFFFF_FFFF : ((32'd1 << (8 * (int'(sz) + 1))) - 32'd1);
      job_words.delete();
      for (int i = 0; i < $urandom_range(1, 5); i++) job_words.push_back($urandom & wm);
      run_job(m, sz, 1'($urandom), 1'($urandom), $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 6), j == 2, 0, 32'd0);
    end

    // Reset during an ACCESS phase.
    job_words.delete();
    issue_start(2'd1, 2'd1, 1'b0, 1'b0, 32'hFFFF, 32'd0, 4);
    feed_word(32'h0000_A5A5, 0);
    t = 0;
    while (!(psel_o && penable_o) && t < 200) begin @(negedge clk); t++; end
    check("reach_access", 32'(psel_o && penable_o), 32'd1);
    #2 rst_i = 1;
    #1;
    check("rst_async_apb", 32'({psel_o, penable_o}), 32'd0);
    check("rst_async_busy", 32'(busy_o), 32'd0);
    sb.delete(); wexp.delete();
    exp_result = 32'd0;
    repeat (3) @(negedge clk);
    rst_i = 0;
    check("rst_result", result_o, 32'd0);

    load_ascii();
    run_job(2'd0, 2'd0, 1'b0, 1'b0, 32'd0, 32'd0, -1, 0, 0, 1, 32'h0000_00F4);

    repeat (5) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
